// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit state encoding and parity helper.
package uart_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int NUMBER_OF_BITS = DATA_WIDTH + 3;
    localparam int STATE_W        = $clog2(NUMBER_OF_BITS);

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 4'd0,
        START_BIT  = 4'd1,
        DATA_BIT_0 = 4'd2,
        DATA_BIT_1 = 4'd3,
        DATA_BIT_2 = 4'd4,
        DATA_BIT_3 = 4'd5,
        DATA_BIT_4 = 4'd6,
        DATA_BIT_5 = 4'd7,
        DATA_BIT_6 = 4'd8,
        DATA_BIT_7 = 4'd9,
        PARITY_BIT = 4'd10,
        STOP_BIT   = 4'd11
    } state_t;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Baud divider: counts clk cycles inside one serial bit; bit_end marks the last cycle.
// Saturates at CLOCKS_PER_BIT-1 until cleared, so a missed clear never wraps into a short bit.
module baud_counter #(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int               CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bit_end = enable && (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready accept -> start, 8 data (LSB first), parity, stop.
// Outputs registered; line low one cycle after accept; tx_ready stays low for the whole frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLOCKS_PER_BIT   = 16,
    parameter bit PARITY_ODD       = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic                        tx_done
);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [INPUT_DATA_WIDTH-1:0] r_shift;
    logic [INPUT_DATA_WIDTH-1:0] w_shift_next;
    logic                        r_parity;
    logic                        w_parity_next;
    logic                        r_serial;
    logic                        w_serial_next;
    logic                        r_ready;
    logic                        r_busy;
    logic                        r_done;
    logic                        w_done_next;
    logic                        w_accept;
    logic                        w_bit_end;
    logic                        w_counting;

    assign w_accept   = tx_valid && r_ready;
    assign w_counting = (r_state != IDLE);

    baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept || w_bit_end),
        .enable (w_counting),
        .bit_end(w_bit_end)
    );

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_done_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next  = START_BIT;
                    w_shift_next  = tx_data;
                    w_parity_next = parity_bit(tx_data, PARITY_ODD);
                end
            end
            START_BIT, PARITY_BIT: begin
                if (w_bit_end) begin
                    w_state_next = state_t'(r_state + STATE_W'(1));
                end
            end
            DATA_BIT_0, DATA_BIT_1, DATA_BIT_2, DATA_BIT_3,
            DATA_BIT_4, DATA_BIT_5, DATA_BIT_6, DATA_BIT_7: begin
                // Shift on leaving a data bit so bit 0 of the register is always the next bit out.
                if (w_bit_end) begin
                    w_state_next = state_t'(r_state + STATE_W'(1));
                    w_shift_next = r_shift >> 1;
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Line value is decoded from the next state so serial_out lines up with tx_busy.
        case (w_state_next)
            START_BIT:  w_serial_next = 1'b0;
            DATA_BIT_0, DATA_BIT_1, DATA_BIT_2, DATA_BIT_3,
            DATA_BIT_4, DATA_BIT_5, DATA_BIT_6, DATA_BIT_7:
                        w_serial_next = w_shift_next[0];
            PARITY_BIT: w_serial_next = w_parity_next;
            default:    w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_serial <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_serial <= w_serial_next;
            r_ready  <= (w_state_next == IDLE);
            r_busy   <= (w_state_next != IDLE);
            r_done   <= w_done_next;
        end
    end

    assign tx_ready   = r_ready;
    assign serial_out = r_serial;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;

`ifdef FORMAL
    a_state_legal: assert property (@(posedge clk) r_state <= STOP_BIT);
    a_idle_high:   assert property (@(posedge clk) (r_state == IDLE) |-> r_serial);
    a_ready_busy:  assert property (@(posedge clk) !(r_ready && r_busy));
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench: even- and odd-parity transmitters driven in lockstep, frames decoded off the line.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 11 * CPB;

    typedef struct {
        logic [10:0] frame;
        int          t;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rst_s    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rdy0, ser0, busy0, done0;
    logic       rdy1, ser1, busy1, done1;
    logic [3:0] o0, o1;

    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;
    int   n_sent    = 0;
    int   frames[2] = '{0, 0};
    int   aborts[2] = '{0, 0};
    exp_t q0[$];
    exp_t q1[$];

    uart_tx #(.INPUT_DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy0), .serial_out(ser0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx #(.INPUT_DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy1), .serial_out(ser1), .tx_busy(busy1), .tx_done(done1)
    );

    assign o0 = {done0, busy0, rdy0, ser0};
    assign o1 = {done1, busy1, rdy1, ser1};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    function automatic logic [3:0] obs(input int w);
        return (w == 0) ? o0 : o1;
    endfunction

    // Reference frame, LSB = first bit on the line.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input bit odd);
        logic p;
        p = (($countones(d) % 2) == 1) ^ odd;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge t.
    task automatic send(input logic [7:0] d, input bit hold, output int t);
        int   n;
        exp_t e;
        tx_data  = d;
        tx_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (rdy0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rdy0 !== 1'b1) begin
            chk("accept_timeout", rdy0, 1);
            t = -1;
        end else begin
            t       = cyc + 1;
            e.t     = t;
            e.frame = model_frame(d, 1'b0);
            q0.push_back(e);
            e.frame = model_frame(d, 1'b1);
            q1.push_back(e);
            n_sent++;
        end
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic monitor(input int w);
        exp_t        e;
        logic [3:0]  s;
        logic [10:0] got;
        bit          have, proto_ok, stable, aborted;
        int          t0;
        forever begin
            @(negedge clk);
            s = obs(w);
            if (rst_s) begin
                chk($sformatf("reset_state_d%0d", w), s, 4'b0001);
                continue;
            end
            if (s[0] !== 1'b0) begin
                chk($sformatf("idle_state_d%0d", w), s, 4'b0011);
                continue;
            end
            t0   = cyc;
            have = 0;
            if (w == 0) begin
                if (q0.size() != 0) begin e = q0.pop_front(); have = 1; end
            end else begin
                if (q1.size() != 0) begin e = q1.pop_front(); have = 1; end
            end
            chk($sformatf("frame_expected_d%0d", w), have, 1);
            proto_ok = 1;
            stable   = 1;
            aborted  = 0;
            got      = '0;
            for (int i = 0; i < FRAME; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    s = obs(w);
                end
                if (rst_s) begin
                    aborted = 1;
                    break;
                end
                if (s[3:1] !== 3'b010) proto_ok = 0;
                if (i % CPB == 0) got[i / CPB] = s[0];
                else if (s[0] !== got[i / CPB]) stable = 0;
            end
            if (aborted) begin
                aborts[w]++;
                chk($sformatf("abort_state_d%0d", w), s, 4'b0001);
            end else begin
                if (have) begin
                    chk($sformatf("frame_bits_d%0d", w), got, e.frame);
                    chk($sformatf("start_time_d%0d", w), t0, e.t);
                end
                chk($sformatf("bit_width_d%0d", w), stable, 1);
                chk($sformatf("busy_ready_in_frame_d%0d", w), proto_ok, 1);
                @(negedge clk);
                s = obs(w);
                chk($sformatf("frame_end_done_d%0d", w), s, 4'b1011);
                frames[w]++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t, t1, t2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs_d0", {done0, rdy0, ser0}, 3'b001);
            chk("reset_outputs_d1", {done1, rdy1, ser1}, 3'b001);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {rdy1, rdy0}, 2'b11);

        fork
            monitor(0);
            monitor(1);
        join_none

        @(posedge clk);
        #1;
        send(8'h55, 1'b0, t);
        send(8'h07, 1'b0, t);
        send(8'hFF, 1'b0, t);

        send(8'hA3, 1'b1, t1);
        send(8'h3C, 1'b0, t2);
        chk("b2b_period", t2 - t1, FRAME + 1);

        send(8'h81, 1'b0, t);
        for (int i = 0; i < 38; i++) begin
            tx_data  = 8'($urandom);
            tx_valid = (i % 9 == 4);
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;

        // Abort inside DATA_BIT_3 (cycles t+16..t+19 of the frame).
        send(8'hC3, 1'b0, t);
        while (cyc < t + 4 * CPB) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h12, 1'b0, t);

        repeat (6) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 1'b0, t);
        end

        repeat (FRAME + 4) @(negedge clk);
        chk("queue_empty_d0", q0.size(), 0);
        chk("queue_empty_d1", q1.size(), 0);
        chk("frames_d0", frames[0], n_sent - 1);
        chk("frames_d1", frames[1], n_sent - 1);
        chk("aborts_d0", aborts[0], 1);
        chk("aborts_d1", aborts[1], 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts a parallel byte on a valid/ready handshake and serialises it onto `serial_out` as one 11-bit frame. The frame is 1 start bit, `INPUT_DATA_WIDTH` data bits (LSB first), 1 parity bit and 1 stop bit, matching the frame format our UART Rx path decodes. The block sits between the host-side byte source and the TX pin. It owns baud timing, framing, parity generation and the transmit state machine.

## Interface
- `INPUT_DATA_WIDTH`, default 8: data bits per frame. The state encoding supports exactly 8.
- `CLOCKS_PER_BIT`, default 16: `clk` cycles per serial bit, ≥2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk  in  1`: single clock. All logic is rising-edge.
- `reset  in  1`: synchronous, active-high reset.
- `tx_data  in  INPUT_DATA_WIDTH`: byte to send. Sampled only on accept.
- `tx_valid  in  1`: a byte is offered.
- `tx_ready  out  1`: the block can accept a byte this cycle.
- `serial_out  out  1`: UART line. Idles high.
- `tx_busy  out  1`: a frame is in progress (state is not IDLE).
- `tx_done  out  1`: one-cycle pulse after the stop bit completes.

## Operation
- All outputs are registered. Reset values: `serial_out`=1, `tx_ready`=0, `tx_busy`=0, `tx_done`=0, state=IDLE, baud counter=0.
- `tx_ready` rises on the first cycle after `reset` deasserts. While in IDLE, `tx_ready`=1.
- Accept: `tx_valid && tx_ready` at a rising edge.
  - On accept, `tx_data` is latched into a shift register and parity is computed from the latched value.
  - Later changes on `tx_data` have no effect on the frame.
- States, 4-bit encoding:
  - IDLE=0, START_BIT=1, DATA_BIT_0..DATA_BIT_7=2..9, PARITY_BIT=10, STOP_BIT=11.
- Transitions:
  - IDLE to START_BIT on accept.
  - Every other state advances by +1 when the baud counter reaches `CLOCKS_PER_BIT-1`.
  - STOP_BIT to IDLE.
  - Any encoding above 11 returns to IDLE.
- Line value per state: START=0; DATA_BIT_n = latched bit n; PARITY = ^data XOR `PARITY_ODD`; STOP=1; IDLE=1.
- Baud counter:
  - Width `$clog2(CLOCKS_PER_BIT)`.
  - Cleared on accept and on every state advance.
  - Increments otherwise while not IDLE, and never wraps past `CLOCKS_PER_BIT-1`.
- `tx_done` pulses in the cycle state returns to IDLE, coincident with `tx_ready` rising.
- Reset mid-frame: at the reset edge the frame aborts, the line returns high, `tx_done` is not pulsed and the latched data is discarded.
- `tx_valid` while busy is ignored. The source must hold `tx_valid` until it sees `tx_ready`.

## Timing
- Accept at edge T:
  - `serial_out`=0 and `tx_ready`=0 are visible from T+1.
  - Each bit occupies exactly `CLOCKS_PER_BIT` cycles.
  - The stop bit ends at T+11·`CLOCKS_PER_BIT`.
  - At T+11·`CLOCKS_PER_BIT`+1, `tx_ready`=1 and `tx_done`=1.
- Back-to-back (`tx_valid` held high): the next accept happens in the first `tx_ready` cycle.
  - Frames repeat every 11·`CLOCKS_PER_BIT`+1 cycles.
  - The high gap is `CLOCKS_PER_BIT`+1 cycles (stop bit plus one idle cycle).
- `tx_busy` = (state != IDLE), registered and aligned with `serial_out`.

## Structure
- Shared package `uart_pkg` holds:
  - the state localparams IDLE..STOP_BIT;
  - `NUMBER_OF_BITS` = `INPUT_DATA_WIDTH`+3;
  - the state width `$clog2(NUMBER_OF_BITS)`.
- One sub-module, `baud_counter`:
  - parameter `CLOCKS_PER_BIT`;
  - inputs `clear` and `enable`;
  - output `bit_end` pulse.
- The FSM, shift register and parity logic stay in `uart_tx`.
- Formal properties (under `FORMAL`):
  - state ≤ 11 at all times;
  - `serial_out`=1 whenever IDLE;
  - `tx_ready` and `tx_busy` are never both 1.

## Test plan
- Reset: `CLOCKS_PER_BIT`=4. Assert `reset` for 3 cycles → `serial_out`=1, `tx_ready`=0 and `tx_done`=0 throughout. `tx_ready`=1 one cycle after release.
- Even parity, 0x55 → line sequence 0, 1,0,1,0,1,0,1,0, 0, 1. Each bit is 4 cycles. `tx_done` pulses exactly 44 cycles after T+1.
- Odd parity (`PARITY_ODD`=1), 0x07 → data bits 1,1,1,0,0,0,0,0 with parity bit 0. With 0xFF the parity bit is 1.
- Back-to-back:
  - Stimulus: `tx_valid` held with 0xA3 then 0x3C.
  - Second start bit begins 45 cycles after the first.
  - Line stays high for 5 cycles between the frames.
  - Decoded bytes are 0xA3 then 0x3C.
- Data stability: change `tx_data` every cycle after accept of 0x81 → the transmitted data bits still encode 0x81. `tx_valid` pulses while busy cause no second frame.
- Reset mid-frame: assert `reset` during DATA_BIT_3 → `serial_out`=1 at the next edge and no `tx_done` pulse. A new byte 0x12 is then sent correctly in full.
